// File: rtl/turn_ctrl_nplayer_if.sv
// Move-entry / checker / display bundle for the N-player turn controller.
// The slave side is the controller; the master side is its environment.
interface turn_ctrl_nplayer_if #(
  parameter int NUM_CELLS = 9,
  parameter int CELL_W    = 4,
  parameter int PID_W     = 2
);
  logic                       start;
  logic                       move_valid;
  logic [CELL_W-1:0]          move;
  logic                       eval_done;
  logic [1:0]                 outcome;
  logic                       eval_req;
  logic                       move_accept;
  logic                       move_reject;
  logic                       timeout_skip;
  logic [NUM_CELLS*PID_W-1:0] board;
  logic [PID_W-1:0]           cur_player;
  logic [CELL_W-1:0]          moves_made;
  logic                       game_over;
  logic [PID_W-1:0]           winner;
  logic                       is_tie;

  modport master (
    output start, move_valid, move, eval_done, outcome,
    input  eval_req, move_accept, move_reject, timeout_skip,
    input  board, cur_player, moves_made, game_over, winner, is_tie
  );

  modport slave (
    input  start, move_valid, move, eval_done, outcome,
    output eval_req, move_accept, move_reject, timeout_skip,
    output board, cur_player, moves_made, game_over, winner, is_tie
  );
endinterface

// File: rtl/turn_ctrl_nplayer.sv
// N-player turn controller: owns the board, checks moves, rotates turns,
// forfeits idle turns and hands win/tie evaluation to an external checker.
module turn_ctrl_nplayer #(
  parameter int NUM_CELLS      = 9,
  parameter int CELL_W         = 4,
  parameter int NUM_PLAYERS    = 2,
  parameter int PID_W          = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16
) (
  input logic clk,
  input logic rst,
  turn_ctrl_nplayer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, WAIT_MOVE, EVAL, DONE
  } state_t;

  state_t state, state_nx;

  logic [NUM_CELLS*PID_W-1:0] board_q, board_nx;
  logic [PID_W-1:0] player_q, player_nx;
  logic [PID_W-1:0] winner_q, winner_nx;
  logic [PID_W-1:0] next_pid;
  logic [CELL_W-1:0] moves_q, moves_nx;
  logic [TMR_W-1:0] timer_q, timer_nx;
  logic tie_q, tie_nx;
  logic acc_q, acc_nx;
  logic rej_q, rej_nx;
  logic skip_q, skip_nx;
  logic legal;
  logic expire;

  // Legal means in range 1..NUM_CELLS and the addressed cell is empty.
  always_comb begin
    legal = 1'b0;
    for (int k = 1; k <= NUM_CELLS; k++) begin
      if (bus.move == CELL_W'(k) &&
          board_q[(k-1)*PID_W +: PID_W] == '0)
        legal = 1'b1;
    end
  end

  assign next_pid = (player_q == PID_W'(NUM_PLAYERS)) ?
                    PID_W'(1) : player_q + 1'b1;

  assign expire = (TIMEOUT_CYCLES != 0) &&
                  (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx  = state;
    board_nx  = board_q;
    player_nx = player_q;
    winner_nx = winner_q;
    moves_nx  = moves_q;
    timer_nx  = timer_q;
    tie_nx    = tie_q;
    acc_nx    = 1'b0;
    rej_nx    = 1'b0;
    skip_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        board_nx  = '0;
        player_nx = PID_W'(1);
        if (bus.start) begin
          state_nx = WAIT_MOVE;
          timer_nx = '0;
        end
      end
      WAIT_MOVE: begin
        timer_nx = timer_q + 1'b1;
        if (bus.move_valid && legal) begin
          for (int k = 1; k <= NUM_CELLS; k++) begin
            if (bus.move == CELL_W'(k))
              board_nx[(k-1)*PID_W +: PID_W] = player_q;
          end
          moves_nx = moves_q + 1'b1;
          acc_nx   = 1'b1;
          state_nx = EVAL;
        end else begin
          rej_nx = bus.move_valid;
          if (expire) begin
            skip_nx   = 1'b1;
            player_nx = next_pid;
            timer_nx  = '0;
          end
        end
      end
      EVAL: begin
        if (bus.eval_done) begin
          if (bus.outcome == 2'd1) begin
            state_nx  = DONE;
            winner_nx = player_q;
          end else if (bus.outcome == 2'd2 ||
                       moves_q == CELL_W'(NUM_CELLS)) begin
            state_nx  = DONE;
            tie_nx    = 1'b1;
            winner_nx = '0;
          end else begin
            state_nx  = WAIT_MOVE;
            player_nx = next_pid;
            timer_nx  = '0;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nx  = WAIT_MOVE;
          board_nx  = '0;
          moves_nx  = '0;
          player_nx = PID_W'(1);
          winner_nx = '0;
          tie_nx    = 1'b0;
          timer_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      board_q  <= '0;
      player_q <= PID_W'(1);
      winner_q <= '0;
      moves_q  <= '0;
      timer_q  <= '0;
      tie_q    <= 1'b0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      board_q  <= board_nx;
      player_q <= player_nx;
      winner_q <= winner_nx;
      moves_q  <= moves_nx;
      timer_q  <= timer_nx;
      tie_q    <= tie_nx;
      acc_q    <= acc_nx;
      rej_q    <= rej_nx;
      skip_q   <= skip_nx;
    end
  end

  assign bus.eval_req     = (state == EVAL);
  assign bus.game_over    = (state == DONE);
  assign bus.move_accept  = acc_q;
  assign bus.move_reject  = rej_q;
  assign bus.timeout_skip = skip_q;
  assign bus.board        = board_q;
  assign bus.cur_player   = player_q;
  assign bus.moves_made   = moves_q;
  assign bus.winner       = winner_q;
  assign bus.is_tie       = tie_q;

endmodule

// File: doc/turn_ctrl_nplayer.md
Name: turn_ctrl_nplayer

Overview:
Parametrised successor to the two-player tic-tac-toe turn FSM. It owns the board state, checks move legality internally (range and occupancy), and rotates turns among NUM_PLAYERS players. It adds a per-turn move timeout and detects a full board. Win/tie evaluation stays in an external checker, reached through a req/done handshake. The block sits between the move-entry/debounce logic and the display/colour mapping logic.

Parameters:
NUM_CELLS, 9, number of board cells; cells are addressed 1..NUM_CELLS.
CELL_W, 4, width of the move index; must satisfy 2^CELL_W > NUM_CELLS.
NUM_PLAYERS, 2, number of players (2..2^PID_W-1).
PID_W, 2, width of a player ID; ID 0 means empty cell / no player.
TIMEOUT_CYCLES, 1000, number of WAIT_MOVE cycles before the turn is forfeited; 0 disables the timeout.
TMR_W, 16, timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous active-high reset
start  in  1  level; begins a game from IDLE or DONE
move_valid  in  1  one-cycle strobe; move is sampled when high
move  in  CELL_W  target cell, 1..NUM_CELLS
eval_done  in  1  checker completion strobe
outcome  in  2  0=in progress, 1=current player wins, 2=tie, 3=reserved
eval_req  out  1  evaluation request; held high until eval_done
move_accept  out  1  one-cycle pulse when a move is committed
move_reject  out  1  one-cycle pulse when a move is illegal
timeout_skip  out  1  one-cycle pulse when a turn is forfeited
board  out  NUM_CELLS*PID_W  cell k (1-based) occupies bits [k*PID_W-1 : (k-1)*PID_W]
cur_player  out  PID_W  player whose turn it is, 1..NUM_PLAYERS
moves_made  out  CELL_W  count of committed moves
game_over  out  1  high while in DONE
winner  out  PID_W  winning player ID; 0 on a tie
is_tie  out  1  high in DONE when the game ended with no winner

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-evaluation) forces state=IDLE and sets every output to its reset value.
  - Reset values: board=0, cur_player=1, moves_made=0, timer=0.
  - All pulses low; eval_req=0, game_over=0, winner=0, is_tie=0.
- States: IDLE, WAIT_MOVE, EVAL, DONE.
- IDLE:
  - board is held at 0 and cur_player at 1.
  - start=1 -> WAIT_MOVE, timer=0.
- WAIT_MOVE, move_valid=1 with a legal move (1<=move<=NUM_CELLS and the cell is 0):
  - At the next edge: cell is written with cur_player, moves_made+1, move_accept=1 for one cycle, eval_req=1, state -> EVAL.
  - Latency from the move_valid edge to board update is 1 cycle.
- WAIT_MOVE, move_valid=1 with an illegal move (move=0, move>NUM_CELLS, or cell occupied):
  - move_reject=1 for one cycle; board unchanged; stay in WAIT_MOVE.
  - The timer keeps counting.
- Timeout (TIMEOUT_CYCLES>0):
  - The timer increments each WAIT_MOVE cycle.
  - When timer==TIMEOUT_CYCLES-1 and no legal move is present that cycle: timeout_skip=1 for one cycle, cur_player advances, timer=0, stay in WAIT_MOVE.
  - A legal move in the same cycle as the timeout has priority; no skip occurs.
  - The timer clears on entry to WAIT_MOVE.
- Player advance: cur_player = (cur_player==NUM_PLAYERS) ? 1 : cur_player+1.
- EVAL:
  - eval_req stays 1; move_valid is ignored, with no accept and no reject pulse.
  - On eval_done=1:
    - eval_req drops at the next edge.
    - outcome=1 -> DONE, winner=cur_player.
    - outcome=2 -> DONE, is_tie=1, winner=0.
    - outcome=0 or 3, with moves_made==NUM_CELLS -> DONE, is_tie=1.
    - outcome=0 or 3, otherwise -> WAIT_MOVE, player advances, timer=0.
  - eval_done is never sampled outside EVAL.
- DONE:
  - game_over=1; board, winner and is_tie are held; move_valid is ignored.
  - start=1 -> board=0, moves_made=0, cur_player=1, winner=0, is_tie=0, state -> WAIT_MOVE (new game in one step).
- The board is written only in WAIT_MOVE on a legal move; no other path modifies a non-zero cell except reset or a restart.

Test Plan:
- Reset, start=1, move=5, move_valid -> next cycle move_accept=1, board[9:8]=2'b01, eval_req=1; eval_done with outcome=0 -> cur_player=2.
- Player 2 sends move=5 (occupied), then move=0, then move=10 -> move_reject pulses 3 times; board unchanged; cur_player stays 2.
- NUM_PLAYERS=3, TIMEOUT_CYCLES=4, no moves -> timeout_skip pulses every 4 cycles; cur_player goes 1,2,3,1.
- Legal move in the same cycle as timer==TIMEOUT_CYCLES-1 -> move_accept=1 and timeout_skip=0.
- Nine legal moves, each answered with outcome=0 -> after the ninth, DONE with is_tie=1, winner=0, moves_made=9; start=1 -> board=0, WAIT_MOVE, cur_player=1.
- outcome=1 after player 2's move -> winner=2, game_over=1. rst=1 while in EVAL with eval_req=1 -> next cycle IDLE, eval_req=0, board=0.
